// File: rtl/alm_antilog_decoder_if.sv
// Handshake/data bundle for the ALM antilog decoder.
//   Input side : in_valid, in_ready, log_concat_format_A {K, frac}, zero_flag
//   Output side: out_valid, out_ready, A_out, range_err
// master: upstream/downstream environment; slave: the decoder.
interface alm_antilog_decoder_if #(
  parameter int A_BW       = 32,
  parameter int LOG2_WIDTH = $clog2(A_BW)
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LOG2_WIDTH+A_BW-2:0]    log_concat_format_A;
  logic                          zero_flag;
  logic                          out_valid;
  logic                          out_ready;
  logic [A_BW-1:0]               A_out;
  logic                          range_err;

  modport master (
    output in_valid, log_concat_format_A, zero_flag, out_ready,
    input  in_ready, out_valid, A_out, range_err
  );

  modport slave (
    input  in_valid, log_concat_format_A, zero_flag, out_ready,
    output in_ready, out_valid, A_out, range_err
  );
endinterface

// File: rtl/alm_antilog_decoder.sv
// ALM antilog decoder: rebuilds a linear A_BW-bit value 2^K * (1 + f) from a
// log-domain operand {K, frac}. Two-stage valid/ready pipeline.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of alm_antilog_decoder_if
//          (in_valid/in_ready/log_concat_format_A/zero_flag in,
//           out_valid/out_ready/A_out/range_err out)
// FRAC_TRUNC zeroes that many fraction LSBs for approximate reconstruction.
module alm_antilog_decoder #(
  parameter int A_BW       = 32,
  parameter int LOG2_WIDTH = $clog2(A_BW),
  parameter int FRAC_TRUNC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  alm_antilog_decoder_if.slave   bus
);

  localparam int FW = A_BW - 1;
  localparam logic [FW-1:0]         FRAC_ONES  = '1;
  localparam logic [FW-1:0]         FRAC_MASK  = FRAC_ONES << FRAC_TRUNC;
  localparam logic [LOG2_WIDTH:0]   K_MAX      = (LOG2_WIDTH+1)'(A_BW - 1);
  localparam logic [LOG2_WIDTH-1:0] SHIFT_BASE = LOG2_WIDTH'(A_BW - 1);

  logic                  s1_valid, s2_valid;
  logic                  s1_adv, s2_adv, in_fire;
  logic [LOG2_WIDTH-1:0] in_k, s1_k;
  logic [FW-1:0]         in_frac, s1_frac;
  logic                  range_err_s1;
  logic                  s1_zero, s1_range;
  logic [A_BW-1:0]       a_next, s2_a;
  logic                  s2_range;

  assign in_k    = bus.log_concat_format_A[LOG2_WIDTH+FW-1 -: LOG2_WIDTH];
  assign in_frac = bus.log_concat_format_A[FW-1:0];

  // Exponent beyond the top bit position: output saturates.
  assign range_err_s1 = {1'b0, in_k} > K_MAX;

  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = s1_valid & s2_adv;
  assign bus.in_ready = ~s1_valid | s2_adv;
  assign in_fire      = bus.in_valid & bus.in_ready;

  // Stage 1: capture operand. A new beat can only be accepted while S1 is
  // empty or draining, so loading always takes priority over clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_frac  <= '0;
      s1_zero  <= 1'b0;
      s1_range <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_k     <= in_k;
      s1_frac  <= in_frac & FRAC_MASK;
      s1_zero  <= bus.zero_flag;
      s1_range <= range_err_s1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Place the implicit leading one at bit K; frac follows it MSB-first.
  always_comb begin
    a_next = {1'b1, s1_frac} >> (SHIFT_BASE - s1_k);
    if (s1_zero) begin
      a_next = '0;
    end else if (s1_range) begin
      a_next = '1;
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_range <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a     <= a_next;
        s2_range <= ~s1_zero & s1_range;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.A_out     = s2_a;
  assign bus.range_err = s2_range;

endmodule

// File: tb/tb_alm_antilog_decoder.sv
module tb_alm_antilog_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alm_antilog_decoder_if #(.A_BW(32))                 if0 ();
  alm_antilog_decoder_if #(.A_BW(32))                 if1 ();
  alm_antilog_decoder_if #(.A_BW(24), .LOG2_WIDTH(5)) if2 ();

  alm_antilog_decoder #(.A_BW(32), .FRAC_TRUNC(0))  dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  alm_antilog_decoder #(.A_BW(32), .FRAC_TRUNC(28)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  alm_antilog_decoder #(.A_BW(24), .LOG2_WIDTH(5), .FRAC_TRUNC(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  k;
    logic [30:0] f;
    logic        zf;
    logic [31:0] a;
    logic        re;
  } vec32_t;

  typedef struct {
    logic [4:0]  k;
    logic [22:0] f;
    logic        zf;
    logic [23:0] a;
    logic        re;
  } vec24_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: K = leading-one position, frac = bits below it, left-aligned.
  function automatic void enc(input logic [31:0] a, output logic [4:0] k, output logic [30:0] f);
    logic [31:0] t;
    k = '0;
    for (int unsigned i = 0; i < 32; i++) if (a[i]) k = 5'(i);
    t = a << (5'd31 - k);
    f = t[30:0];
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] a;
    a = $urandom >> $urandom_range(0, 31);
    if (a == 0) a = 32'd1;
    return a;
  endfunction

  // Single beat through dut0 on an idle pipeline; returns result and latency.
  task automatic run_vec(input logic [4:0] k, input logic [30:0] f, input logic zf,
                         output logic [31:0] a, output logic re, output int lat);
    @(negedge clk);
    if0.in_valid = 1'b1;
    if0.log_concat_format_A = {k, f};
    if0.zero_flag = zf;
    if0.out_ready = 1'b1;
    #1 chk("idle_in_ready", 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    lat = 1;
    #1;
    while (!if0.out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    a  = if0.A_out;
    re = if0.range_err;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec32_t tv[6];
    vec32_t tv1[3];
    vec24_t tv2[5];
    logic [31:0] bp_a[3];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic [31:0] a_res, cur_a;
    logic [4:0]  kk;
    logic [30:0] ff;
    logic        re_res;
    int          lat;

    tv[0] = '{5'd4,  31'h18000000, 1'b0, 32'h00000013, 1'b0};
    tv[1] = '{5'd31, 31'h00000000, 1'b0, 32'h80000000, 1'b0};
    tv[2] = '{5'd0,  31'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0};
    tv[3] = '{5'd17, 31'h5555AAAA, 1'b1, 32'h00000000, 1'b0};
    tv[4] = '{5'd1,  31'h40000000, 1'b0, 32'h00000003, 1'b0};
    tv[5] = '{5'd8,  31'h7F800000, 1'b0, 32'h000001FF, 1'b0};

    tv1[0] = '{5'd4,  31'h18000000, 1'b0, 32'h00000012, 1'b0};
    tv1[1] = '{5'd0,  31'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0};
    tv1[2] = '{5'd31, 31'h7FFFFFFF, 1'b0, 32'hF0000000, 1'b0};

    tv2[0] = '{5'd24, 23'h000000, 1'b0, 24'hFFFFFF, 1'b1};
    tv2[1] = '{5'd23, 23'h000000, 1'b0, 24'h800000, 1'b0};
    tv2[2] = '{5'd31, 23'h7FFFFF, 1'b0, 24'hFFFFFF, 1'b1};
    tv2[3] = '{5'd24, 23'h000000, 1'b1, 24'h000000, 1'b0};
    tv2[4] = '{5'd4,  23'h180000, 1'b0, 24'h000013, 1'b0};

    bp_a[0] = 32'h00001234;
    bp_a[1] = 32'hDEADBEEF;
    bp_a[2] = 32'h00000001;

    if0.in_valid = 0; if0.out_ready = 0; if0.zero_flag = 0; if0.log_concat_format_A = '0;
    if1.in_valid = 0; if1.out_ready = 1; if1.zero_flag = 0; if1.log_concat_format_A = '0;
    if2.in_valid = 0; if2.out_ready = 1; if2.zero_flag = 0; if2.log_concat_format_A = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_A_out",     64'(if0.A_out),     64'd0);
    chk("rst_range_err", 64'(if0.range_err), 64'd0);
    chk("rst_in_ready",  64'(if0.in_ready),  64'd1);
    rst = 1'b0;

    // Directed vectors, A_BW=32 exact
    for (int i = 0; i < 6; i++) begin
      run_vec(tv[i].k, tv[i].f, tv[i].zf, a_res, re_res, lat);
      chk($sformatf("vec%0d_A_out", i),     64'(a_res),  64'(tv[i].a));
      chk($sformatf("vec%0d_range_err", i), 64'(re_res), 64'(tv[i].re));
      chk($sformatf("vec%0d_latency", i),   64'(lat),    64'd2);
    end

    // FRAC_TRUNC=28 instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.log_concat_format_A = {tv1[i].k, tv1[i].f};
      if1.zero_flag = tv1[i].zf;
      @(negedge clk);
      if1.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("trunc%0d_out_valid", i), 64'(if1.out_valid), 64'd1);
      chk($sformatf("trunc%0d_A_out", i),     64'(if1.A_out),     64'(tv1[i].a));
      chk($sformatf("trunc%0d_range_err", i), 64'(if1.range_err), 64'(tv1[i].re));
    end

    // A_BW=24 instance: saturation and top-of-range
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if2.in_valid = 1'b1;
      if2.log_concat_format_A = {tv2[i].k, tv2[i].f};
      if2.zero_flag = tv2[i].zf;
      @(negedge clk);
      if2.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("bw24_%0d_out_valid", i), 64'(if2.out_valid), 64'd1);
      chk($sformatf("bw24_%0d_A_out", i),     64'(if2.A_out),     64'(tv2[i].a));
      chk($sformatf("bw24_%0d_range_err", i), 64'(if2.range_err), 64'(tv2[i].re));
    end

    // Backpressure: three beats offered with out_ready low
    @(negedge clk);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    enc(bp_a[0], kk, ff); if0.log_concat_format_A = {kk, ff}; if0.zero_flag = 1'b0;
    #1 chk("bp_in_ready_0", 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    enc(bp_a[1], kk, ff); if0.log_concat_format_A = {kk, ff};
    #1 chk("bp_in_ready_1", 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    enc(bp_a[2], kk, ff); if0.log_concat_format_A = {kk, ff};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready_full", 64'(if0.in_ready),  64'd0);
      chk("bp_out_valid",     64'(if0.out_valid), 64'd1);
      chk("bp_A_out_held",    64'(if0.A_out),     64'(bp_a[0]));
      @(negedge clk);
    end
    if0.out_ready = 1'b1;
    begin
      bit acc;
      acc = 1'b0;
      got.delete();
      for (int i = 0; i < 10; i++) begin
        #1;
        if (if0.out_valid && if0.out_ready) got.push_back(if0.A_out);
        if (if0.in_valid && if0.in_ready) acc = 1'b1;
        @(negedge clk);
        if (acc) if0.in_valid = 1'b0;
      end
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(bp_a[i]));

    // Round trip stream: 200 beats at full rate, then random valid/ready
    begin
      int  sent, recv, c;
      bit  fire, prev_stall;
      logic [31:0] prev_a, e;
      sent = 0; recv = 0; c = 0; prev_stall = 0; prev_a = '0;
      exp_q.delete();
      cur_a = rand_a();
      enc(cur_a, kk, ff);
      if0.log_concat_format_A = {kk, ff};
      if0.zero_flag = 1'b0;
      if0.in_valid  = 1'b1;
      if0.out_ready = 1'b1;
      while (recv < 1000 && c < 20000) begin
        #1;
        if (prev_stall) begin
          chk("stall_out_valid_held", 64'(if0.out_valid), 64'd1);
          chk("stall_A_out_held",     64'(if0.A_out),     64'(prev_a));
        end
        if (c < 200) chk("full_rate_in_ready", 64'(if0.in_ready), 64'd1);
        if (c >= 2 && c < 200) chk("full_rate_out_valid", 64'(if0.out_valid), 64'd1);
        if (if0.out_valid && if0.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(if0.A_out), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("roundtrip_A_out", 64'(if0.A_out), 64'(e));
          end
          recv++;
        end
        prev_stall = if0.out_valid & ~if0.out_ready;
        prev_a     = if0.A_out;
        fire = if0.in_valid & if0.in_ready;
        if (fire) begin
          exp_q.push_back(cur_a);
          sent++;
        end
        @(negedge clk);
        c++;
        if (fire || !if0.in_valid) begin
          if (sent < 1000) begin
            cur_a = rand_a();
            enc(cur_a, kk, ff);
            if0.log_concat_format_A = {kk, ff};
            if0.in_valid = (sent < 200) ? 1'b1 : 1'($urandom_range(0, 1));
          end else begin
            if0.in_valid = 1'b0;
          end
        end
        if0.out_ready = (sent < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      chk("stream_received", 64'(recv), 64'd1000);
      chk("stream_leftover", 64'(exp_q.size()), 64'd0);
    end

    // Reset mid-stream drops in-flight beats
    @(negedge clk);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    enc(32'h0000_BEEF, kk, ff); if0.log_concat_format_A = {kk, ff};
    @(negedge clk);
    enc(32'h0FF0_0000, kk, ff); if0.log_concat_format_A = {kk, ff};
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1 chk("pre_rst_out_valid", 64'(if0.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("mid_rst_in_ready",  64'(if0.in_ready),  64'd1);
    chk("mid_rst_A_out",     64'(if0.A_out),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    if0.out_ready = 1'b1;
    begin
      bit stale;
      stale = 1'b0;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (if0.out_valid) stale = 1'b1;
        @(negedge clk);
      end
      chk("post_rst_no_stale", 64'(stale), 64'd0);
    end
    enc(32'h0000_0013, kk, ff);
    run_vec(kk, ff, 1'b0, a_res, re_res, lat);
    chk("post_rst_A_out",   64'(a_res), 64'h13);
    chk("post_rst_latency", 64'(lat),   64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
